// File: rtl/genius_pkg.sv
// Shared types and helpers for the Genius (Simon) game blocks.
package genius_pkg;

  localparam int COLOR_W = 2;
  localparam int IDX_W   = 4;

  localparam logic [COLOR_W-1:0] GREEN  = 2'd0;
  localparam logic [COLOR_W-1:0] RED    = 2'd1;
  localparam logic [COLOR_W-1:0] YELLOW = 2'd2;
  localparam logic [COLOR_W-1:0] BLUE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Colour code to one-hot lamp vector (bit0 green .. bit3 blue).
  function automatic logic [3:0] color_onehot(input logic [COLOR_W-1:0] c);
    return 4'b0001 << c;
  endfunction

endpackage

// File: rtl/genius_lfsr.sv
// Free-running 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
module genius_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       R,
  output logic [7:0] state
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Shift left, feeding back the XOR of taps 8, 6, 5 and 4.
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // LFSR register; advances every cycle out of reset.
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge R) begin
    if (!R) lfsr_q <= SEED;
    else    lfsr_q <= lfsr_d;
  end

  assign state = lfsr_q;

endmodule

// File: rtl/genius_seq_player.sv
// Genius sequence player: appends one colour per round and plays the
// first N+1 stored colours on the LEDs with fixed on/off timing.
// Build option: GENIUS_FIXED_SEQ_EN appends colour N mod 4 instead of
// the LFSR colour, for deterministic bring-up.
module genius_seq_player
  import genius_pkg::*;
#(
  parameter int         SEQ_MAX   = 16,
  parameter int         ON_CYC    = 4,
  parameter int         OFF_CYC   = 2,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic               clk,
  input  logic               R,
  input  logic               start,
  input  logic [IDX_W-1:0]   round,
  output logic [3:0]         led,
  output logic               busy,
  output logic               done,
  input  logic [IDX_W-1:0]   chk_idx,
  output logic [COLOR_W-1:0] chk_color
);

  localparam int TMR_MAX = ((ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC) - 1;
  localparam int TMR_W   = (TMR_MAX > 0) ? $clog2(TMR_MAX + 1) : 1;
  localparam logic [TMR_W-1:0] ON_LAST  = TMR_W'(ON_CYC - 1);
  localparam logic [TMR_W-1:0] OFF_LAST = TMR_W'(OFF_CYC - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   n_q, n_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   idx_inc;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [3:0]         led_q, led_d;
  logic [COLOR_W-1:0] mem_q [SEQ_MAX];
  logic               wr_en;
  logic [COLOR_W-1:0] new_color;
  logic [7:0]         lfsr_state;
  logic               unused_lfsr;

  genius_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .R     (R),
    .state (lfsr_state)
  );

`ifdef GENIUS_FIXED_SEQ_EN
  assign new_color   = round[COLOR_W-1:0];
  assign unused_lfsr = ^lfsr_state;
`else
  assign new_color   = lfsr_state[COLOR_W-1:0];
  assign unused_lfsr = ^lfsr_state[7:COLOR_W];
`endif

  assign idx_inc = idx_q + 1'b1;

  // Next-state logic; led_d is computed for the coming state so the lamp register is glitch-free.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    led_d   = '0;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          n_d     = round;
          idx_d   = '0;
          timer_d = '0;
          wr_en   = 1'b1;
          state_d = ON;
          // For N=0 the first colour is the one being written at this edge.
          led_d   = color_onehot((round == '0) ? new_color : mem_q[0]);
        end
      end
      ON: begin
        if (timer_q == ON_LAST) begin
          timer_d = '0;
          state_d = OFF;
        end else begin
          timer_d = timer_q + 1'b1;
          led_d   = color_onehot(mem_q[idx_q]);
        end
      end
      OFF: begin
        if (timer_q == OFF_LAST) begin
          timer_d = '0;
          if (idx_q == n_q) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_inc;
            state_d = ON;
            led_d   = color_onehot(mem_q[idx_inc]);
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control registers and registered lamp output.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_q <= IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      led_q   <= led_d;
    end
  end

  // Colour sequence storage, appended at mem[N] when a round is accepted.
  // NOTE: the sequence must read as all-zero after reset, so this array is reset flops, not a RAM macro.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      mem_q <= '{default: '0};
    end else if (wr_en) begin
      mem_q[round] <= new_color;
    end
  end

  assign led       = led_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign chk_color = mem_q[chk_idx];

endmodule

// File: tb/tb_genius_seq_player.sv
// Scoreboard bench for genius_seq_player: stimulus pushes expected LED
// runs and busy lengths, a monitor compresses the LED stream into runs
// and compares them as they complete.
module tb_genius_seq_player;
  import genius_pkg::*;

  localparam int ON_CYC  = 4;
  localparam int OFF_CYC = 2;

  logic       clk     = 1'b0;
  logic       R       = 1'b1;
  logic       start   = 1'b0;
  logic [3:0] round   = '0;
  logic [3:0] chk_idx = '0;
  logic [3:0] led;
  logic       busy;
  logic       done;
  logic [1:0] chk_color;

  genius_seq_player #(
    .SEQ_MAX   (16),
    .ON_CYC    (ON_CYC),
    .OFF_CYC   (OFF_CYC),
    .LFSR_SEED (8'hA5)
  ) dut (
    .clk       (clk),
    .R         (R),
    .start     (start),
    .round     (round),
    .led       (led),
    .busy      (busy),
    .done      (done),
    .chk_idx   (chk_idx),
    .chk_color (chk_color)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] led;
    int         len;
  } run_t;

  run_t       exp_run_q [$];
  int         exp_busy_q[$];
  logic [1:0] exp_mem   [16];
  int         vec_cnt  = 0;
  int         err_cnt  = 0;
  int         done_cnt = 0;

  // Reference LFSR: x^8+x^6+x^5+x^4+1 from seed A5, shifting every cycle.
  logic [7:0] m_lfsr;
  always @(posedge clk or negedge R) begin
    if (!R) m_lfsr <= 8'hA5;
    else    m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] lamp(input logic [1:0] c);
    case (c)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0010;
      2'd2:    return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  // Accept a round: predict the appended colour and push the whole playback.
  task automatic issue(input int n);
    logic [1:0] c;
    @(negedge clk);
`ifdef GENIUS_FIXED_SEQ_EN
    c = 2'(n % 4);
`else
    c = m_lfsr[1:0];
`endif
    start   = 1'b1;
    round   = 4'(n);
    chk_idx = 4'(n);
    #1 check("chk_before_write", 32'(chk_color), 32'(exp_mem[n]));
    exp_mem[n] = c;
    for (int i = 0; i <= n; i++) begin
      exp_run_q.push_back(run_t'{lamp(exp_mem[i]), ON_CYC});
      exp_run_q.push_back(run_t'{4'b0000, OFF_CYC});
    end
    exp_busy_q.push_back((n + 1) * (ON_CYC + OFF_CYC) + 1);
    @(negedge clk);
    start = 1'b0;
    check("chk_after_write", 32'(chk_color), 32'(exp_mem[n]));
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("idle_within_budget", 32'(busy), 32'd0);
  endtask

  // Monitor state.
  logic [3:0] run_led = '0;
  int         run_len = 0;
  int         busy_len = 0;

  task automatic close_run();
    run_t e;
    if (exp_run_q.size() == 0) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL unexpected_run: actual led=%b len=%0d, required none", run_led, run_len);
    end else begin
      e = exp_run_q.pop_front();
      check("run_led", 32'(run_led), 32'(e.led));
      check("run_len", 32'(run_len), 32'(e.len));
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!R) begin
        run_len  = 0;
        busy_len = 0;
      end else if (busy) begin
        busy_len++;
        if (done) begin
          if (run_len > 0) close_run();
          run_len = 0;
          check("led_dark_in_done", 32'(led), 32'd0);
          if (exp_busy_q.size() == 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL unexpected_done: actual busy_len=%0d, required no done", busy_len);
          end else begin
            check("busy_len", 32'(busy_len), 32'(exp_busy_q.pop_front()));
          end
          busy_len = 0;
          done_cnt++;
        end else if (run_len > 0 && led == run_led) begin
          run_len++;
        end else begin
          if (run_len > 0) close_run();
          run_led = led;
          run_len = 1;
        end
      end else begin
        check("done_only_when_busy", 32'(done), 32'd0);
      end
    end
  end

  int d0;

  initial begin : stimulus
    for (int i = 0; i < 16; i++) exp_mem[i] = '0;

    // Reset state and memory cleared.
    #1 R = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_led", 32'(led), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk_idx = 4'(i);
      #1 check("rst_mem", 32'(chk_color), 32'd0);
    end
    @(negedge clk);
    R = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_without_start", 32'(busy), 32'd0);

    // Rounds 0..3 in turn.
    for (int n = 0; n < 4; n++) begin
      issue(n);
      wait_idle(200);
    end
    chk_idx = 4'd2;
    #1 check("chk_idx2", 32'(chk_color), 32'(exp_mem[2]));
`ifdef GENIUS_FIXED_SEQ_EN
    check("chk_idx2_fixed", 32'(chk_color), 32'd2);
`endif

    // Re-issue round 2, then poke start/round while it plays.
    issue(2);
    repeat (2) @(negedge clk);
    start = 1'b1;
    round = 4'd7;
    @(negedge clk);
    start = 1'b0;
    round = 4'd9;
    wait_idle(200);
    chk_idx = 4'd7;
    #1 check("mem7_untouched", 32'(chk_color), 32'd0);

    // Fill 4..14, then the deepest round 15.
    for (int n = 4; n < 16; n++) begin
      issue(n);
      wait_idle(200);
    end
    for (int i = 0; i < 16; i++) begin
      chk_idx = 4'(i);
      #1 check("mem_contents", 32'(chk_color), 32'(exp_mem[i]));
    end
    check("done_count", 32'(done_cnt), 32'd17);

    // Reset in the middle of an ON period of round 5.
    issue(5);
    repeat (2) @(negedge clk);
    #2 R = 1'b0;
    #1;
    check("midrst_led", 32'(led), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    exp_run_q.delete();
    exp_busy_q.delete();
    for (int i = 0; i < 16; i++) exp_mem[i] = '0;
    for (int i = 0; i < 16; i++) begin
      chk_idx = 4'(i);
      #1 check("midrst_mem", 32'(chk_color), 32'd0);
    end
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    check("no_done_after_reset", 32'(done_cnt), 32'(d0));

    // Colour right after reset: same timing twice, then one cycle later.
    for (int run = 0; run < 3; run++) begin
      R = 1'b0;
      for (int i = 0; i < 16; i++) exp_mem[i] = '0;
      @(negedge clk);
      R = 1'b1;
      if (run == 2) @(negedge clk);
      issue(0);
      wait_idle(50);
      chk_idx = 4'd0;
`ifdef GENIUS_FIXED_SEQ_EN
      #1 check("seed_color", 32'(chk_color), 32'd0);
`else
      // Start is sampled with LFSR 4A (runs 0,1) or 95 (run 2).
      #1 check("seed_color", 32'(chk_color), (run == 2) ? 32'd1 : 32'd2);
`endif
      @(negedge clk);
    end

    check("runs_drained", 32'(exp_run_q.size()), 32'd0);
    check("busy_drained", 32'(exp_busy_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
